// File: rtl/alu_pkg.sv
// Shared definitions for the sequential add/subtract unit: FSM states,
// mode encoding and bit positions of the flags in the condition-code word.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operation mode carried on the 'sub' input.
    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    // Bit positions inside the condition-code word.
    localparam int CC_ZF     = 0;
    localparam int CC_SF     = 1;
    localparam int CC_OF     = 2;
    localparam int CC_CF     = 3;
    localparam int CC_NFLAGS = 4;

endpackage

// File: rtl/addsub_slice.sv
// One SLICE-bit chunk of the adder/subtractor. 'm' inverts b so that with
// cin=1 the chunk computes a-b. c_msb_in is the carry into the top bit of
// the chunk; together with cout it yields signed overflow on the last chunk.
module addsub_slice #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  logic             m,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [SLICE-1:0] bx;
    logic [SLICE:0]   full;

    // Plain ripple add; the carry into the MSB is recovered from the sum bit.
    always_comb begin
        bx       = b ^ {SLICE{m}};
        full     = {1'b0, a} + {1'b0, bx} + {{SLICE{1'b0}}, cin};
        s        = full[SLICE-1:0];
        cout     = full[SLICE];
        c_msb_in = full[SLICE-1] ^ a[SLICE-1] ^ bx[SLICE-1];
    end

endmodule

// File: rtl/alu_addsub_seq.sv
// Multi-cycle WIDTH-bit add/subtract unit working SLICE bits per clock.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready is high only in IDLE, out_valid only in DONE, and a
// result leaves DONE on the edge where out_ready is seen, so a new operation
// can be accepted at the earliest one edge later.
module alu_addsub_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zf,
    output logic             sf
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         cnt;
    logic                  carry;
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      b_q;
    logic                  sub_q;
    logic [WIDTH-1:0]      work;
    logic [WIDTH-1:0]      work_next;
    logic [WIDTH-1:0]      result_q;
    logic [CC_NFLAGS-1:0]  flags_q;
    int                    shamt;
    logic [SLICE-1:0]      a_sl;
    logic [SLICE-1:0]      b_sl;
    logic [SLICE-1:0]      s_sl;
    logic                  c_out_sl;
    logic                  c_msb_sl;
    logic                  accept;
    logic                  last;

    assign accept = in_valid && (state == IDLE);
    assign last   = (state == RUN) && (cnt == LAST);

    // Select the operand chunk addressed by the counter and merge the new
    // sum chunk into the working result.
    always_comb begin
        shamt     = int'(cnt) * SLICE;
        a_sl      = SLICE'(a_q >> shamt);
        b_sl      = SLICE'(b_q >> shamt);
        work_next = (work & ~(SLICE_MASK << shamt)) | (WIDTH'(s_sl) << shamt);
    end

    addsub_slice #(.SLICE(SLICE)) u_slice (
        .a        (a_sl),
        .b        (b_sl),
        .cin      (carry),
        .m        (sub_q),
        .s        (s_sl),
        .cout     (c_out_sl),
        .c_msb_in (c_msb_sl)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, chunk counter, carry chain and result/flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry    <= 1'b0;
            cnt      <= '0;
            work     <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            carry <= (sub == ALU_SUB);
            cnt   <= '0;
            work  <= '0;
        end else if (state == RUN) begin
            work  <= work_next;
            carry <= c_out_sl;
            if (last) begin
                result_q         <= work_next;
                flags_q[CC_ZF]   <= (work_next == '0);
                flags_q[CC_SF]   <= work_next[WIDTH-1];
                flags_q[CC_OF]   <= c_msb_sl ^ c_out_sl;
                flags_q[CC_CF]   <= c_out_sl;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign result   = result_q;
    assign cout     = flags_q[CC_CF];
    assign overflow = flags_q[CC_OF];
    assign zf       = flags_q[CC_ZF];
    assign sf       = flags_q[CC_SF];

endmodule

// File: tb/tb_alu_addsub_seq.sv
// Bench for alu_addsub_seq: three instances (SLICE = 16, 64, 1) share the
// operand inputs; each is exercised in turn while the others sit idle.
module tb_alu_addsub_seq;

    localparam int W  = 64;
    localparam int ND = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [ND-1:0]         in_valid;
    logic [ND-1:0]         in_ready;
    logic [ND-1:0]         out_valid;
    logic [ND-1:0]         out_ready;
    logic [ND-1:0]         cout;
    logic [ND-1:0]         overflow;
    logic [ND-1:0]         zf;
    logic [ND-1:0]         sf;
    logic [ND-1:0][W-1:0]  result;
    logic [W-1:0]          a;
    logic [W-1:0]          b;
    logic                  sub;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        alu_addsub_seq #(
            .WIDTH (W),
            .SLICE ((g == 0) ? 16 : ((g == 1) ? 64 : 1))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .a         (a),
            .b         (b),
            .sub       (sub),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .result    (result[g]),
            .cout      (cout[g]),
            .overflow  (overflow[g]),
            .zf        (zf[g]),
            .sf        (sf[g])
        );
    end

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // ---------------- scoreboard state ----------------
    logic [W+3:0] exp_q[$];
    int           due_q[$];
    int           cur  = 0;
    bit           seen = 1'b0;
    int           total = 0;
    int           bad   = 0;

    function automatic int nslice(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 64);
    endfunction

    // Reference: whole-word arithmetic, flags from two's-complement rules.
    function automatic logic [W+3:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        logic [W:0]   full;
        logic [W-1:0] r;
        logic         c;
        logic         ov;
        if (s) full = {1'b0, x} - {1'b0, y};
        else   full = {1'b0, x} + {1'b0, y};
        r  = full[W-1:0];
        c  = s ? (x >= y) : full[W];
        ov = s ? ((x[W-1] != y[W-1]) && (r[W-1] != x[W-1]))
               : ((x[W-1] == y[W-1]) && (r[W-1] != x[W-1]));
        return {r, c, ov, (r == '0), r[W-1]};
    endfunction

    task automatic chk(input string name, input logic [W+7:0] act, input logic [W+7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut=%0d: got %h want %h", name, cur, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W+3:0] e;
        logic [W+3:0] act;
        int           d;
        if (!rst) begin
            if (out_valid[cur] && !seen) begin
                seen = 1'b1;
                total++;
                if (due_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid dut=%0d at cycle %0d", cur, cycle);
                end else begin
                    d = due_q.pop_front();
                    if (cycle != d) begin
                        bad++;
                        $display("FAIL latency dut=%0d: out_valid at cycle %0d want %0d", cur, cycle, d);
                    end
                end
            end
            if (out_valid[cur] && out_ready[cur]) begin
                seen = 1'b0;
                act  = {result[cur], cout[cur], overflow[cur], zf[cur], sf[cur]};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result dut=%0d: got %h", cur, act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        bad++;
                        $display("FAIL result dut=%0d: got {res,cf,of,zf,sf}=%h want %h", cur, act, e);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input int d, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input bit expect_it);
        int n = 0;
        a = x;
        b = y;
        sub = s;
        if (expect_it) exp_q.push_back(model(x, y, s));
        in_valid[d] = 1'b1;
        while (!in_ready[d] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready[d]) begin
            total++;
            bad++;
            $display("FAIL accept_timeout dut=%0d", d);
            in_valid[d] = 1'b0;
            if (expect_it) void'(exp_q.pop_back());
            return;
        end
        @(posedge clk); #1;
        if (expect_it) due_q.push_back(cycle + nslice(d));
        in_valid[d] = 1'b0;
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            out_ready[d] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        out_ready[d] = 1'b0;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout dut=%0d pending=%0d", d, exp_q.size());
            exp_q.delete();
            due_q.delete();
        end
    endtask

    task automatic run_op(input int d, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s);
        issue(d, x, y, s, 1'b1);
        drain(d);
    endtask

    task automatic backpressure(input int d);
        logic [W+7:0] snap;
        int n = 0;
        issue(d, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
        // Foreign operation offered while busy: must be ignored.
        a = 64'hDEAD_BEEF_0000_0001;
        b = 64'h1234;
        in_valid[d] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        in_valid[d] = 1'b0;
        while (!out_valid[d] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_done", {7'd0, out_valid[d]}, 1);
        snap = {3'd0, out_valid[d], in_ready[d], result[d], cout[d], overflow[d], zf[d], sf[d]};
        in_valid[d] = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold_stable",
                {3'd0, out_valid[d], in_ready[d], result[d], cout[d], overflow[d], zf[d], sf[d]},
                snap);
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        chk("idle_after_release", {in_ready[d], out_valid[d]}, 2'b10);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic mid_reset(input int d);
        int k = (nslice(d) > 2) ? 2 : 0;
        issue(d, 64'hFFFF_0000_FFFF_0000, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
        repeat (k) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_outputs",
            {in_ready[d], out_valid[d], result[d], cout[d], overflow[d], zf[d], sf[d]},
            {1'b1, 1'b0, {W{1'b0}}, 4'b0000});
        #3 rst = 1'b0;
        seen = 1'b0;
        @(posedge clk); #1;
        run_op(d, 64'd10, 64'd20, 1'b0);
    endtask

    task automatic suite(input int d);
        logic [W-1:0] x;
        logic [W-1:0] y;
        cur = d;
        run_op(d, 64'd5, 64'd7, 1'b0);
        run_op(d, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1);
        run_op(d, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        run_op(d, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        run_op(d, 64'd3, 64'd5, 1'b1);
        run_op(d, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
        backpressure(d);
        mid_reset(d);
        repeat (10) begin
            case ($urandom_range(0, 3))
                0: begin x = {$urandom, $urandom}; y = {$urandom, $urandom}; end
                1: begin x = 64'($urandom_range(0, 20)); y = 64'($urandom_range(0, 20)); end
                2: begin x = ~64'($urandom_range(0, 3)); y = 64'($urandom_range(0, 3)); end
                default: begin x = {$urandom, $urandom}; y = x; end
            endcase
            run_op(d, x, y, 1'($urandom_range(0, 1)));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            cur = d;
            chk("reset_values",
                {in_ready[d], out_valid[d], result[d], cout[d], overflow[d], zf[d], sf[d]},
                {1'b1, 1'b0, {W{1'b0}}, 4'b0000});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) suite(d);
        repeat (5) @(posedge clk);
        #1;
        chk("leftover_expected", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d", cycle);
        $fatal(1, "simulation time limit reached");
    end

endmodule
